// File: rtl/qsys_cpu_div_cell.sv
// Iterative radix-2 restoring divider for div/divu: one quotient bit per clock,
// start/busy/done handshake, quotient + remainder + divide-by-zero flag.
module qsys_cpu_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             A_div_start,
  input  logic             A_div_signed,
  input  logic [WIDTH-1:0] A_div_src1,
  input  logic [WIDTH-1:0] A_div_src2,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_quotient,
  output logic [WIDTH-1:0] A_div_remainder,
  output logic             A_div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sg);
    if (sg && v[WIDTH-1]) begin
      return negate(v);
    end else begin
      return v;
    end
  endfunction

  state_t           state_r;
  logic [CW-1:0]    count_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             zero_r;
  logic [WIDTH-1:0] src1_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quot_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             by_zero_r;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] trial_s;
  logic             ok_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] quot_next_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    shifted_s   = {rem_r, quot_r[WIDTH-1]};
    trial_s     = {1'b0, shifted_s} - {2'b00, div_r};
    ok_s        = ~trial_s[WIDTH+1];
    rem_next_s  = shifted_s[WIDTH-1:0];
    quot_next_s = {quot_r[WIDTH-2:0], ok_s};
    if (ok_s) begin
      rem_next_s = trial_s[WIDTH-1:0];
    end else begin
      rem_next_s = shifted_s[WIDTH-1:0];
    end
  end

  // Sign correction of the magnitude result, or the forced divide-by-zero result.
  always_comb begin
    q_fix_s = quot_r;
    r_fix_s = rem_r;
    if (zero_r) begin
      q_fix_s = {WIDTH{1'b1}};
      r_fix_s = src1_r;
    end else begin
      q_fix_s = neg_q_r ? negate(quot_r) : quot_r;
      r_fix_s = neg_r_r ? negate(rem_r) : rem_r;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      zero_r      <= 1'b0;
      src1_r      <= {WIDTH{1'b0}};
      div_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      quot_r      <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      by_zero_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (A_div_start) begin
            neg_q_r <= A_div_signed & (A_div_src1[WIDTH-1] ^ A_div_src2[WIDTH-1]);
            neg_r_r <= A_div_signed & A_div_src1[WIDTH-1];
            zero_r  <= (A_div_src2 == {WIDTH{1'b0}});
            src1_r  <= A_div_src1;
            div_r   <= abs_val(A_div_src2, A_div_signed);
            quot_r  <= abs_val(A_div_src1, A_div_signed);
            rem_r   <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b1;
          rem_r   <= rem_next_s;
          quot_r  <= quot_next_s;
          count_r <= count_r + CNT_ONE;
          if (count_r == CNT_LAST) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          quotient_r  <= q_fix_s;
          remainder_r <= r_fix_s;
          by_zero_r   <= zero_r;
          done_r      <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign A_div_busy      = busy_r;
  assign A_div_done      = done_r;
  assign A_div_quotient  = quotient_r;
  assign A_div_remainder = remainder_r;
  assign A_div_by_zero   = by_zero_r;

endmodule

// File: doc/qsys_cpu_div_cell.md
Name: qsys_cpu_div_cell

Overview:
- Iterative 32-bit integer divider for the CPU datapath. It is the inverse-operation companion to the multiplier cell.
- Executes div/divu as a radix-2 restoring divider, one quotient bit per clock.
- Uses a start/busy/done handshake so the A-stage can stall until the result is ready.
- Returns quotient and remainder, plus a divide-by-zero flag.

Parameters:
- WIDTH, 32, operand/result width; latency scales with it (WIDTH+2 cycles).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- A_div_start  in  1  request; accepted only while in IDLE.
- A_div_signed  in  1  1 = signed (div), 0 = unsigned (divu); sampled with start.
- A_div_src1  in  WIDTH  dividend; sampled with start.
- A_div_src2  in  WIDTH  divisor; sampled with start.
- A_div_busy  out  1  high while an operation is in progress.
- A_div_done  out  1  one-cycle pulse; results are valid in this cycle.
- A_div_quotient  out  WIDTH  quotient, truncated toward zero.
- A_div_remainder  out  WIDTH  remainder; takes the sign of the dividend.
- A_div_by_zero  out  1  set together with done when the divisor was 0; holds until the next done.

Behaviour:
- Reset (reset_n low at an edge):
  - State goes to IDLE; busy, done, quotient, remainder and by_zero all go to 0.
  - Reset overrides any in-flight operation; no done is produced for it.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - If A_div_start is 1 at an edge: latch the signed flag and the operand signs, compute |src1| and |src2| (raw values when unsigned), clear the partial remainder and count=0, go to CALC.
  - Absolute value of the most negative number is 0x80000000, treated as unsigned.
- CALC, one step per cycle for WIDTH cycles:
  - Shift {rem, quot} left by 1.
  - Trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and set the quotient LSB to 1.
  - When count == WIDTH-1, go to FIX.
- FIX, one cycle:
  - Negate the quotient if signed and the operand signs differ.
  - Negate the remainder if signed and the dividend was negative.
  - Register the results, pulse done for the next cycle, return to IDLE.
- Timing:
  - Start high in cycle 0 -> busy high in cycles 1..WIDTH+1 -> done high in cycle WIDTH+2 (cycle 34 at default).
  - Busy is low in the done cycle, and a new start is accepted in that same cycle.
- Start while busy is ignored: no queueing, and the in-flight operation is unaffected.
- Inputs are only sampled at start; changes to src1, src2 or signed during busy have no effect.
- Outputs hold their last values between operations. done is a single-cycle pulse.
- Divide by zero:
  - Full latency is still used.
  - Forced result: quotient = all ones, remainder = the original src1 (unsigned and signed alike), by_zero = 1.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0, by_zero = 0; this falls out naturally from the abs/negate path.
- Arithmetic: the trial subtractor is WIDTH+1 bits wide so that dividends with the MSB set are correct in unsigned mode.

Test Plan:
- Unsigned 100 / 7, start in cycle 0 -> done exactly in cycle 34 with quotient 14 and remainder 2; busy high in cycles 1–33 only.
- Signed 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- Signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, by_zero 0.
- Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- 0x12345678 / 0, run once signed and once unsigned -> quotient 0xFFFFFFFF, remainder 0x12345678, by_zero 1.
- A following 9 / 3 -> by_zero clears, quotient 3, remainder 0.
- Start 100 / 7; pulse start again with 50 / 5 in cycle 10 -> the second start is ignored, done only in cycle 34 with result 14 r 2.
- Back-to-back start issued in the done cycle -> accepted, second done in cycle 68.
- Drop reset_n low in cycle 15 of an operation -> all outputs 0 after the edge, no done follows.
- After release, a new 9 / 3 -> correct result 34 cycles later.
